// File: rtl/instr_rx_pkg.sv
// Shared definitions for the UART instruction-word receiver.
//   rx_state_e     : byte framing FSM state encoding (3 bits)
//   UART_DATA_BITS : data bits per UART character
//   width_for()    : ceil(log2(n)) with a floor of 1, for counter sizing
package instr_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Smallest w with 2**w >= n; never below 1 so zero-width vectors cannot appear.
  function automatic int width_for(input longint unsigned n);
    int w;
    w = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte framer: 2-flop synchronizer, framing FSM, optional parity check.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   i_rx_serial     : asynchronous UART line, idle high
//   o_byte_valid    : one-cycle pulse, o_byte holds a good character
//   o_byte          : received character (first bit received in bit 0)
//   o_frame_err     : one-cycle pulse, stop bit sampled low
//   o_parity_err    : one-cycle pulse, parity mismatch with a good stop bit
//   o_state         : current FSM state (debug visibility)
module uart_byte_rx
  import instr_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_rx_serial,
  output logic                      o_byte_valid,
  output logic [UART_DATA_BITS-1:0] o_byte,
  output logic                      o_frame_err,
  output logic                      o_parity_err,
  output rx_state_e                 o_state
);

  localparam int              CNT_W   = width_for(longint'(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  logic                      r_sync1;
  logic                      r_sync2;
  rx_state_e                 r_state;
  logic [CNT_W-1:0]          r_clk_cnt;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_par_bad;
  logic                      r_byte_valid;
  logic                      r_frame_err;
  logic                      r_parity_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= ST_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_sync1      <= i_rx_serial;
      r_sync2      <= r_sync1;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          r_par_bad <= 1'b0;
          if (!r_sync2) r_state <= ST_START;
        end
        ST_START: begin
          // Re-check the line at half a bit: a high line here was only a glitch.
          if (r_clk_cnt == MID_CNT) begin
            r_clk_cnt <= '0;
            r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == BIT_END) begin
            r_clk_cnt <= '0;
            // Shift in from the top so the first bit ends up in bit 0.
            r_shift   <= {r_sync2, r_shift[UART_DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_clk_cnt == BIT_END) begin
            r_clk_cnt <= '0;
            r_par_bad <= (r_sync2 != ((^r_shift) ^ PARITY_ODD));
            r_state   <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_clk_cnt == BIT_END) begin
            r_clk_cnt <= '0;
            r_state   <= ST_IDLE;
            // A framing error outranks a parity error on the same character.
            if (!r_sync2)       r_frame_err  <= 1'b1;
            else if (r_par_bad) r_parity_err <= 1'b1;
            else                r_byte_valid <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_shift;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_state      = r_state;

endmodule

// File: rtl/instr_word_rx.sv
// Instruction-word receiver: assembles BYTES_PER_WORD UART characters into one
// word and presents it through a single holding register.
// Handshake: a word transfers on any cycle where o_word_valid and i_word_ready
// are both high; o_word is held stable while o_word_valid is high and not taken.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   i_rx_serial    : asynchronous UART line, idle high
//   o_word_valid   : o_word holds a complete word
//   i_word_ready   : consumer accepts o_word
//   o_word         : received word, first byte in bits [7:0]
//   o_frame_err    : one-cycle pulse, stop bit low
//   o_parity_err   : one-cycle pulse, parity mismatch
//   o_timeout      : one-cycle pulse, partial word dropped after inter-byte gap
//   o_overrun      : one-cycle pulse, completed word dropped (holding reg full)
module instr_word_rx
  import instr_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 217,
  parameter int BYTES_PER_WORD = 2,
  parameter bit PARITY_EN      = 1'b0,
  parameter bit PARITY_ODD     = 1'b0,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_rx_serial,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic [8*BYTES_PER_WORD-1:0]   o_word,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_timeout,
  output logic                          o_overrun
);

  localparam int               WORD_W   = UART_DATA_BITS * BYTES_PER_WORD;
  localparam int               IDX_W    = width_for(longint'(BYTES_PER_WORD));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam longint unsigned  TO_LIMIT = longint'(TIMEOUT_BITS) * longint'(CLKS_PER_BIT);

  logic                      w_byte_valid;
  logic [UART_DATA_BITS-1:0] w_byte;
  logic                      w_frame_err;
  logic                      w_parity_err;
  rx_state_e                 w_state;
  logic                      w_last;
  logic                      w_to_hit;
  logic [WORD_W-1:0]         w_word;

  logic [IDX_W-1:0]          r_byte_idx;
  logic [WORD_W-1:0]         r_asm;
  logic [WORD_W-1:0]         r_word;
  logic                      r_valid;
  logic                      r_timeout;
  logic                      r_overrun;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_EN    (PARITY_EN),
    .PARITY_ODD   (PARITY_ODD)
  ) u_byte_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_serial  (i_rx_serial),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err),
    .o_parity_err (w_parity_err),
    .o_state      (w_state)
  );

  assign w_last = w_byte_valid && (r_byte_idx == LAST_IDX);

  // Complete word as it would look with the incoming byte merged into its slot.
  always_comb begin
    w_word = r_asm;
    w_word[{r_byte_idx, 3'b000} +: UART_DATA_BITS] = w_byte;
  end

  generate
    if (TIMEOUT_BITS > 0) begin : g_timeout
      localparam int            TO_W   = width_for(TO_LIMIT + 1);
      localparam logic [TO_W-1:0] TO_END = TO_W'(TO_LIMIT - 1);
      logic [TO_W-1:0] r_to_cnt;

      // Only idle time inside a partially received word counts.
      assign w_to_hit = (w_state == ST_IDLE) && (r_byte_idx != '0) && (r_to_cnt == TO_END);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_to_cnt <= '0;
        end else if ((w_state != ST_IDLE) || (r_byte_idx == '0) || w_to_hit) begin
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;

      // Word assembly: any bad character throws away the whole partial word.
      if (w_frame_err || w_parity_err) begin
        r_byte_idx <= '0;
        r_asm      <= '0;
      end else if (w_byte_valid) begin
        if (w_last) begin
          r_byte_idx <= '0;
          r_asm      <= '0;
        end else begin
          r_asm[{r_byte_idx, 3'b000} +: UART_DATA_BITS] <= w_byte;
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end else if (w_to_hit) begin
        r_byte_idx <= '0;
        r_asm      <= '0;
        r_timeout  <= 1'b1;
      end

      // Holding register: a same-cycle transfer frees the slot for the new word.
      if (w_last) begin
        if (!r_valid || i_word_ready) begin
          r_word  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_word_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;
  assign o_frame_err  = w_frame_err;
  assign o_parity_err = w_parity_err;
  assign o_timeout    = r_timeout;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_instr_word_rx.sv
// Directed bench for instr_word_rx: main instance (no parity, 4-bit-time
// timeout) and a second instance with even parity enabled.
module tb_instr_word_rx;

  localparam int CPB = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rx, ready;
  logic        valid, ferr, perr, tout, ovr;
  logic [15:0] word;
  logic        rx_p, ready_p;
  logic        valid_p, ferr_p, perr_p, tout_p, ovr_p;
  logic [15:0] word_p;

  instr_word_rx #(
    .CLKS_PER_BIT(CPB), .BYTES_PER_WORD(2), .PARITY_EN(1'b0),
    .PARITY_ODD(1'b0), .TIMEOUT_BITS(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_rx_serial(rx), .o_word_valid(valid),
    .i_word_ready(ready), .o_word(word), .o_frame_err(ferr),
    .o_parity_err(perr), .o_timeout(tout), .o_overrun(ovr)
  );

  instr_word_rx #(
    .CLKS_PER_BIT(CPB), .BYTES_PER_WORD(2), .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0), .TIMEOUT_BITS(20)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .i_rx_serial(rx_p), .o_word_valid(valid_p),
    .i_word_ready(ready_p), .o_word(word_p), .o_frame_err(ferr_p),
    .o_parity_err(perr_p), .o_timeout(tout_p), .o_overrun(ovr_p)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          c_ferr, c_perr, c_tout, c_ovr, c_vcyc, c_ferr_p, c_perr_p;
  int          tout_cyc;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_qp[$];
  logic [15:0] got_qp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    c_ferr = 0; c_perr = 0; c_tout = 0; c_ovr = 0; c_vcyc = 0;
    c_ferr_p = 0; c_perr_p = 0; tout_cyc = -1;
  endtask

  // Observe the values the coming rising edge will act on, then advance.
  task automatic sample();
    cyc++;
    if (valid) c_vcyc++;
    if (valid && ready) got_q.push_back(word);
    if (ferr) c_ferr++;
    if (perr) c_perr++;
    if (ovr)  c_ovr++;
    if (tout) begin c_tout++; tout_cyc = cyc; end
    if (valid_p && ready_p) got_qp.push_back(word_p);
    if (ferr_p) c_ferr_p++;
    if (perr_p) c_perr_p++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    drive_line(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, d[i]);
      tick(CPB);
    end
    if (has_par) begin
      drive_line(sel, par);
      tick(CPB);
    end
    drive_line(sel, stop);
    tick(CPB);
    drive_line(sel, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_words_p(input string tag);
    check({tag, "_count"}, got_qp.size(), exp_qp.size());
    while (got_qp.size() > 0 && exp_qp.size() > 0) check(tag, got_qp.pop_front(), exp_qp.pop_front());
    got_qp.delete();
    exp_qp.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; ready = 1'b1; ready_p = 1'b1;
    clear_counts();
    @(negedge clk);
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_word", word, 0);
    check("rst_pulses", {ferr, perr, tout, ovr}, 0);
    rst_n = 1'b1;
    tick(2);

    // Scenario 1: two good bytes, ready high.
    clear_counts();
    send_byte(8'h34); send_byte(8'h12); tick(20);
    exp_q.push_back(16'h1234);
    check_words("s1_word");
    check("s1_valid_cycles", c_vcyc, 1);
    check("s1_errors", c_ferr + c_perr + c_tout + c_ovr, 0);

    // All-ones / all-zeros byte values.
    clear_counts();
    send_byte(8'hFF); send_byte(8'h00); tick(20);
    exp_q.push_back(16'h00FF);
    check_words("s1b_word");

    // Scenario 2: bad stop bit, then a good word.
    clear_counts();
    send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b0); tick(16);
    check("s2_ferr", c_ferr, 1);
    send_byte(8'hAA); send_byte(8'h55); tick(20);
    exp_q.push_back(16'h55AA);
    check_words("s2_word");
    check("s2_ferr_total", c_ferr, 1);

    // Frame error after a good first byte drops the partial word.
    clear_counts();
    send_byte(8'h34);
    send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b0); tick(16);
    send_byte(8'hAA); send_byte(8'h55); tick(20);
    exp_q.push_back(16'h55AA);
    check_words("s2b_word");
    check("s2b_ferr", c_ferr, 1);

    // Scenario 3: even parity, 0x07 needs parity bit 1.
    clear_counts();
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1); tick(16);
    check("s3_perr", c_perr_p, 1);
    check("s3_ferr", c_ferr_p, 0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    send_frame(1'b1, 8'h00, 1'b1, 1'b0, 1'b1); tick(20);
    exp_qp.push_back(16'h0007);
    check_words_p("s3_word");
    check("s3_perr_total", c_perr_p, 1);

    // Scenario 4: inter-byte timeout of 4 bit times = 32 cycles.
    clear_counts();
    send_byte(8'h34);
    lat = cyc;
    tick(40);
    check("s4_timeout", c_tout, 1);
    check("s4_timeout_window", ((tout_cyc - lat) >= 24 && (tout_cyc - lat) <= 38) ? 1 : 0, 1);
    send_byte(8'h01); send_byte(8'h02); tick(20);
    exp_q.push_back(16'h0201);
    check_words("s4_word");
    check("s4_timeout_total", c_tout, 1);

    // Scenario 5: holding register full, second word overruns.
    clear_counts();
    ready = 1'b0;
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22); tick(10);
    check("s5_word_held", word, 16'h1111);
    check("s5_valid_held", valid, 1);
    check("s5_overrun", c_ovr, 1);
    ready = 1'b1;
    tick(3);
    check("s5_valid_fell", valid, 0);
    exp_q.push_back(16'h1111);
    check_words("s5_word");

    // Scenario 6: short glitch ignored; reset drops a half-received word.
    clear_counts();
    rx = 1'b0; tick(3); rx = 1'b1; tick(30);
    check("s6_glitch_words", got_q.size(), 0);
    check("s6_glitch_errs", c_ferr + c_perr + c_tout + c_ovr, 0);
    send_byte(8'h77); tick(2);
    rst_n = 1'b0; tick(1);
    check("s6_rst_word", word, 0);
    check("s6_rst_valid", valid, 0);
    tick(1);
    rst_n = 1'b1; tick(4);
    send_byte(8'hCD); send_byte(8'hAB); tick(20);
    exp_q.push_back(16'hABCD);
    check_words("s6_word");
    check("s6_errs", c_ferr + c_perr + c_tout + c_ovr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
